// File: rtl/id_stage_blk.sv
// RV32I instruction-decode stage: control decode, immediate generation, 32x32
// register file with WB write-through, load-use detection and the ID/EX register.
module id_stage_blk #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            CLK,
    input  logic            RSTB,
    input  logic [31:0]     IF_ID_INST_IN,
    input  logic [XLEN-1:0] IF_ID_PC_IN,
    input  logic            ID_STALL,
    input  logic            ID_FLUSH,
    input  logic            WB_REG_WRITE,
    input  logic [4:0]      WB_RD,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            HAZARD_STALL,
    output logic [XLEN-1:0] ID_EX_PC_OUT,
    output logic [XLEN-1:0] ID_EX_RS1_DATA,
    output logic [XLEN-1:0] ID_EX_RS2_DATA,
    output logic [XLEN-1:0] ID_EX_IMM,
    output logic [4:0]      ID_EX_RS1,
    output logic [4:0]      ID_EX_RS2,
    output logic [4:0]      ID_EX_RD,
    output logic [2:0]      ID_EX_FUNCT3,
    output logic            ID_EX_FUNCT7B5,
    output logic            ID_EX_REG_WRITE,
    output logic            ID_EX_MEM_READ,
    output logic            ID_EX_MEM_WRITE,
    output logic            ID_EX_BRANCH,
    output logic            ID_EX_JUMP,
    output logic            ID_EX_ALU_SRC,
    output logic            ID_EX_MEM_TO_REG,
    output logic            ID_EX_VALID,
    output logic            ID_EX_ILLEGAL
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            alu_src;
        logic            mem_to_reg;
        logic            valid;
        logic            illegal;
    } id_ex_t;

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] regs [NREGS];
    logic            wb_en;
    logic            uses_rs1;
    logic            uses_rs2;
    id_ex_t          dec;
    id_ex_t          id_ex_q;

    assign inst   = IF_ID_INST_IN;
    assign opcode = inst[6:0];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    assign wb_en = WB_REG_WRITE && (WB_RD != 5'd0);

    // NOTE: the register file is reset like any other state here; x0 is never
    // written, so its entry stays zero and reads of x0 are forced to zero anyway.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[WB_RD] <= WB_DATA;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dec          = '0;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b0;
        dec.pc       = IF_ID_PC_IN;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = inst[11:7];
        dec.funct3   = inst[14:12];
        dec.funct7b5 = inst[30];
        dec.valid    = 1'b1;
        dec.rs1_data = (rs1 == 5'd0) ? '0 : (wb_en && WB_RD == rs1) ? WB_DATA : regs[rs1];
        dec.rs2_data = (rs2 == 5'd0) ? '0 : (wb_en && WB_RD == rs2) ? WB_DATA : regs[rs2];
        case (opcode)
            OP_R:      begin dec.reg_write = 1'b1; uses_rs2 = 1'b1; end
            OP_IALU:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_i; end
            OP_LOAD:   begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm        = imm_i;
            end
            OP_STORE:  begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_s; uses_rs2 = 1'b1; end
            OP_BRANCH: begin dec.branch = 1'b1; dec.imm = imm_b; uses_rs2 = 1'b1; end
            OP_JAL:    begin
                dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_j; uses_rs1 = 1'b0;
            end
            OP_JALR:   begin dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_i; end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_u; uses_rs1 = 1'b0;
            end
            default:   dec.illegal = 1'b1;
        endcase
    end

    assign HAZARD_STALL = id_ex_q.mem_read && id_ex_q.valid && (id_ex_q.rd != 5'd0) &&
                          ((uses_rs1 && id_ex_q.rd == rs1) || (uses_rs2 && id_ex_q.rd == rs2));

    // Flush beats stall; a hazard only injects a bubble when the register is free to move.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            id_ex_q <= '0;
        end else if (ID_FLUSH) begin
            id_ex_q <= '0;
        end else if (!ID_STALL) begin
            id_ex_q <= HAZARD_STALL ? '0 : dec;
        end
    end

    assign ID_EX_PC_OUT     = id_ex_q.pc;
    assign ID_EX_RS1_DATA   = id_ex_q.rs1_data;
    assign ID_EX_RS2_DATA   = id_ex_q.rs2_data;
    assign ID_EX_IMM        = id_ex_q.imm;
    assign ID_EX_RS1        = id_ex_q.rs1;
    assign ID_EX_RS2        = id_ex_q.rs2;
    assign ID_EX_RD         = id_ex_q.rd;
    assign ID_EX_FUNCT3     = id_ex_q.funct3;
    assign ID_EX_FUNCT7B5   = id_ex_q.funct7b5;
    assign ID_EX_REG_WRITE  = id_ex_q.reg_write;
    assign ID_EX_MEM_READ   = id_ex_q.mem_read;
    assign ID_EX_MEM_WRITE  = id_ex_q.mem_write;
    assign ID_EX_BRANCH     = id_ex_q.branch;
    assign ID_EX_JUMP       = id_ex_q.jump;
    assign ID_EX_ALU_SRC    = id_ex_q.alu_src;
    assign ID_EX_MEM_TO_REG = id_ex_q.mem_to_reg;
    assign ID_EX_VALID      = id_ex_q.valid;
    assign ID_EX_ILLEGAL    = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage_blk.sv
// Directed bench for id_stage_blk: decode, immediates, register file, load-use
// hazard and flush/stall priority, with hand-computed expectations.
module tb_id_stage_blk;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b1;
    logic [31:0] IF_ID_INST_IN = '0;
    logic [31:0] IF_ID_PC_IN = '0;
    logic        ID_STALL = 1'b0;
    logic        ID_FLUSH = 1'b0;
    logic        WB_REG_WRITE = 1'b0;
    logic [4:0]  WB_RD = '0;
    logic [31:0] WB_DATA = '0;
    logic        HAZARD_STALL;
    logic [31:0] ID_EX_PC_OUT, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM;
    logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
    logic [2:0]  ID_EX_FUNCT3;
    logic        ID_EX_FUNCT7B5, ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE;
    logic        ID_EX_BRANCH, ID_EX_JUMP, ID_EX_ALU_SRC, ID_EX_MEM_TO_REG;
    logic        ID_EX_VALID, ID_EX_ILLEGAL;

    int checks = 0;
    int failures = 0;

    // {REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, JUMP, ALU_SRC, MEM_TO_REG, VALID, ILLEGAL}
    logic [8:0] ctrl;
    assign ctrl = {ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_JUMP,
                   ID_EX_ALU_SRC, ID_EX_MEM_TO_REG, ID_EX_VALID, ID_EX_ILLEGAL};

    localparam logic [8:0] C_BUBBLE = 9'b000000000;
    localparam logic [8:0] C_IALU   = 9'b100001010;
    localparam logic [8:0] C_STORE  = 9'b001001010;
    localparam logic [8:0] C_BRANCH = 9'b000100010;
    localparam logic [8:0] C_JAL    = 9'b100011010;
    localparam logic [8:0] C_LOAD   = 9'b110001110;
    localparam logic [8:0] C_R      = 9'b100000010;
    localparam logic [8:0] C_ILL    = 9'b000000011;

    localparam logic [31:0] I_ADDI_X1_X5 = 32'h00028093;
    localparam logic [31:0] I_ADDI_X1_X0 = 32'h00000093;
    localparam logic [31:0] I_SW         = 32'hFE20AE23;
    localparam logic [31:0] I_BEQ        = 32'hFE000CE3;
    localparam logic [31:0] I_LUI        = 32'h123451B7;
    localparam logic [31:0] I_JAL        = 32'h008000EF;
    localparam logic [31:0] I_LW_X6      = 32'h0000A303;
    localparam logic [31:0] I_ADD_X7     = 32'h002303B3;
    localparam logic [31:0] I_LW_X0      = 32'h0000A003;
    localparam logic [31:0] I_ADD_X0     = 32'h000003B3;
    localparam logic [31:0] I_ILLEGAL    = 32'h0000007F;

    id_stage_blk #(.XLEN(32), .NREGS(32)) dut (
        .CLK(CLK), .RSTB(RSTB),
        .IF_ID_INST_IN(IF_ID_INST_IN), .IF_ID_PC_IN(IF_ID_PC_IN),
        .ID_STALL(ID_STALL), .ID_FLUSH(ID_FLUSH),
        .WB_REG_WRITE(WB_REG_WRITE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .HAZARD_STALL(HAZARD_STALL),
        .ID_EX_PC_OUT(ID_EX_PC_OUT), .ID_EX_RS1_DATA(ID_EX_RS1_DATA),
        .ID_EX_RS2_DATA(ID_EX_RS2_DATA), .ID_EX_IMM(ID_EX_IMM),
        .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
        .ID_EX_FUNCT3(ID_EX_FUNCT3), .ID_EX_FUNCT7B5(ID_EX_FUNCT7B5),
        .ID_EX_REG_WRITE(ID_EX_REG_WRITE), .ID_EX_MEM_READ(ID_EX_MEM_READ),
        .ID_EX_MEM_WRITE(ID_EX_MEM_WRITE), .ID_EX_BRANCH(ID_EX_BRANCH),
        .ID_EX_JUMP(ID_EX_JUMP), .ID_EX_ALU_SRC(ID_EX_ALU_SRC),
        .ID_EX_MEM_TO_REG(ID_EX_MEM_TO_REG), .ID_EX_VALID(ID_EX_VALID),
        .ID_EX_ILLEGAL(ID_EX_ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        IF_ID_INST_IN = inst;
        IF_ID_PC_IN   = pc;
    endtask

    task automatic test_reset();
        #2 RSTB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IF_ID_INST_IN = $urandom;
            IF_ID_PC_IN   = $urandom;
            WB_REG_WRITE  = 1'($urandom);
            WB_RD         = 5'($urandom);
            WB_DATA       = $urandom;
            step();
        end
        checks++;
        if (ctrl !== C_BUBBLE) begin
            failures++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_BUBBLE);
        end
        checks++;
        if ({ID_EX_PC_OUT, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM} !== 128'd0) begin
            failures++; $display("FAIL reset_data: got %h %h %h %h expected 0",
                                 ID_EX_PC_OUT, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM);
        end
        checks++;
        if ({ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_FUNCT3, ID_EX_FUNCT7B5, HAZARD_STALL} !== 20'd0) begin
            failures++; $display("FAIL reset_fields: got rs1=%0d rs2=%0d rd=%0d f3=%0d f7=%b hz=%b expected 0",
                                 ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_FUNCT3, ID_EX_FUNCT7B5, HAZARD_STALL);
        end
        WB_REG_WRITE = 1'b0;
        WB_RD = '0;
        WB_DATA = '0;
        issue(I_ADDI_X1_X5, 32'h0000_0010);
        #2 RSTB = 1'b1;
        step();
        checks++;
        if (ID_EX_RS1_DATA !== 32'd0 || ID_EX_VALID !== 1'b1) begin
            failures++; $display("FAIL reset_x5_read: got %h valid=%b expected 00000000 valid=1",
                                 ID_EX_RS1_DATA, ID_EX_VALID);
        end
    endtask

    task automatic test_write_through();
        WB_REG_WRITE = 1'b1; WB_RD = 5'd5; WB_DATA = 32'hDEADBEEF;
        issue(I_ADDI_X1_X5, 32'h0000_0100);
        step();
        WB_REG_WRITE = 1'b0;
        checks++;
        if (ID_EX_RS1_DATA !== 32'hDEADBEEF || ID_EX_IMM !== 32'd0 || ID_EX_RD !== 5'd1 ||
            ID_EX_PC_OUT !== 32'h100) begin
            failures++; $display("FAIL write_through_data: got rs1d=%h imm=%h rd=%0d pc=%h expected deadbeef 0 1 100",
                                 ID_EX_RS1_DATA, ID_EX_IMM, ID_EX_RD, ID_EX_PC_OUT);
        end
        checks++;
        if (ctrl !== C_IALU) begin
            failures++; $display("FAIL write_through_ctrl: got %b expected %b", ctrl, C_IALU);
        end
        issue(I_ADDI_X1_X5, 32'h0000_0104);
        step();
        checks++;
        if (ID_EX_RS1_DATA !== 32'hDEADBEEF) begin
            failures++; $display("FAIL stored_x5: got %h expected deadbeef", ID_EX_RS1_DATA);
        end
    endtask

    task automatic test_immediates();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        logic [8:0]  ctrls [4];
        insts = '{I_SW, I_BEQ, I_LUI, I_JAL};
        imms  = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000008};
        ctrls = '{C_STORE, C_BRANCH, C_IALU, C_JAL};
        for (int i = 0; i < 4; i++) begin
            issue(insts[i], 32'h0000_0200 + 32'(i * 4));
            step();
            checks++;
            if (ID_EX_IMM !== imms[i] || ctrl !== ctrls[i]) begin
                failures++; $display("FAIL imm_%0d: got imm=%h ctrl=%b expected imm=%h ctrl=%b",
                                     i, ID_EX_IMM, ctrl, imms[i], ctrls[i]);
            end
        end
    endtask

    task automatic test_load_use();
        issue(I_LW_X6, 32'h0000_0300);
        #1;
        checks++;
        if (HAZARD_STALL !== 1'b0) begin
            failures++; $display("FAIL lu_pre_hazard: got %b expected 0", HAZARD_STALL);
        end
        step();
        checks++;
        if (ctrl !== C_LOAD || ID_EX_RD !== 5'd6 || ID_EX_FUNCT3 !== 3'd2) begin
            failures++; $display("FAIL lu_load: got ctrl=%b rd=%0d f3=%0d expected %b 6 2",
                                 ctrl, ID_EX_RD, ID_EX_FUNCT3, C_LOAD);
        end
        issue(I_ADD_X7, 32'h0000_0304);
        #1;
        checks++;
        if (HAZARD_STALL !== 1'b1) begin
            failures++; $display("FAIL lu_hazard: got %b expected 1", HAZARD_STALL);
        end
        step();
        checks++;
        if (ctrl !== C_BUBBLE || HAZARD_STALL !== 1'b0) begin
            failures++; $display("FAIL lu_bubble: got ctrl=%b hz=%b expected %b 0", ctrl, HAZARD_STALL, C_BUBBLE);
        end
        step();
        checks++;
        if (ctrl !== C_R || ID_EX_RS1 !== 5'd6 || ID_EX_RS2 !== 5'd2 || ID_EX_RD !== 5'd7 ||
            ID_EX_IMM !== 32'd0 || ID_EX_PC_OUT !== 32'h304 || HAZARD_STALL !== 1'b0) begin
            failures++; $display("FAIL lu_issue: got ctrl=%b rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h hz=%b",
                                 ctrl, ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_IMM, ID_EX_PC_OUT, HAZARD_STALL);
        end
    endtask

    task automatic test_x0();
        WB_REG_WRITE = 1'b1; WB_RD = 5'd0; WB_DATA = 32'hFFFFFFFF;
        issue(I_ADDI_X1_X0, 32'h0000_0400);
        step();
        WB_REG_WRITE = 1'b0;
        checks++;
        if (ID_EX_RS1_DATA !== 32'd0) begin
            failures++; $display("FAIL x0_write_through: got %h expected 00000000", ID_EX_RS1_DATA);
        end
        step();
        checks++;
        if (ID_EX_RS1_DATA !== 32'd0) begin
            failures++; $display("FAIL x0_read: got %h expected 00000000", ID_EX_RS1_DATA);
        end
        issue(I_LW_X0, 32'h0000_0408);
        step();
        issue(I_ADD_X0, 32'h0000_040C);
        #1;
        checks++;
        if (HAZARD_STALL !== 1'b0 || ID_EX_MEM_READ !== 1'b1) begin
            failures++; $display("FAIL x0_no_stall: got hz=%b mem_read=%b expected 0 1", HAZARD_STALL, ID_EX_MEM_READ);
        end
        step();
        checks++;
        if (ctrl !== C_R || ID_EX_RD !== 5'd7) begin
            failures++; $display("FAIL x0_consumer: got ctrl=%b rd=%0d expected %b 7", ctrl, ID_EX_RD, C_R);
        end
    endtask

    task automatic test_flush_stall();
        issue(I_ADDI_X1_X5, 32'h0000_0500);
        step();
        ID_FLUSH = 1'b1; ID_STALL = 1'b1;
        issue(I_SW, 32'h0000_0504);
        step();
        ID_FLUSH = 1'b0; ID_STALL = 1'b0;
        checks++;
        if (ctrl !== C_BUBBLE || ID_EX_PC_OUT !== 32'd0) begin
            failures++; $display("FAIL flush_over_stall: got ctrl=%b pc=%h expected %b 0", ctrl, ID_EX_PC_OUT, C_BUBBLE);
        end
        issue(I_LUI, 32'h0000_0508);
        step();
        ID_STALL = 1'b1;
        issue(I_SW, 32'h0000_050C);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ID_EX_PC_OUT !== 32'h508 || ID_EX_IMM !== 32'h12345000 || ctrl !== C_IALU) begin
                failures++; $display("FAIL stall_hold_%0d: got pc=%h imm=%h ctrl=%b expected 508 12345000 %b",
                                     i, ID_EX_PC_OUT, ID_EX_IMM, ctrl, C_IALU);
            end
        end
        ID_STALL = 1'b0;
        step();
        checks++;
        if (ID_EX_PC_OUT !== 32'h50C || ctrl !== C_STORE) begin
            failures++; $display("FAIL stall_release: got pc=%h ctrl=%b expected 50c %b", ID_EX_PC_OUT, ctrl, C_STORE);
        end
    endtask

    task automatic test_hazard_combos();
        // Flush together with a hazard: bubble, hazard still visible that cycle.
        issue(I_LW_X6, 32'h0000_0600);
        step();
        issue(I_ADD_X7, 32'h0000_0604);
        ID_FLUSH = 1'b1;
        #1;
        checks++;
        if (HAZARD_STALL !== 1'b1) begin
            failures++; $display("FAIL flush_hazard_hz: got %b expected 1", HAZARD_STALL);
        end
        step();
        ID_FLUSH = 1'b0;
        checks++;
        if (ctrl !== C_BUBBLE) begin
            failures++; $display("FAIL flush_hazard_bubble: got %b expected %b", ctrl, C_BUBBLE);
        end
        // Stall together with a hazard: hold the load, hazard stays up.
        issue(I_LW_X6, 32'h0000_0608);
        step();
        issue(I_ADD_X7, 32'h0000_060C);
        ID_STALL = 1'b1;
        step();
        checks++;
        if (ctrl !== C_LOAD || ID_EX_PC_OUT !== 32'h608 || HAZARD_STALL !== 1'b1) begin
            failures++; $display("FAIL stall_hazard_hold: got ctrl=%b pc=%h hz=%b expected %b 608 1",
                                 ctrl, ID_EX_PC_OUT, HAZARD_STALL, C_LOAD);
        end
        ID_STALL = 1'b0;
        step();
        checks++;
        if (ctrl !== C_BUBBLE || HAZARD_STALL !== 1'b0) begin
            failures++; $display("FAIL stall_hazard_bubble: got ctrl=%b hz=%b expected %b 0", ctrl, HAZARD_STALL, C_BUBBLE);
        end
        step();
        checks++;
        if (ctrl !== C_R || ID_EX_RS1 !== 5'd6 || ID_EX_PC_OUT !== 32'h60C) begin
            failures++; $display("FAIL stall_hazard_issue: got ctrl=%b rs1=%0d pc=%h expected %b 6 60c",
                                 ctrl, ID_EX_RS1, ID_EX_PC_OUT, C_R);
        end
    endtask

    task automatic test_illegal();
        issue(I_ILLEGAL, 32'h0000_0700);
        step();
        checks++;
        if (ctrl !== C_ILL || ID_EX_PC_OUT !== 32'h700) begin
            failures++; $display("FAIL illegal: got ctrl=%b pc=%h expected %b 700", ctrl, ID_EX_PC_OUT, C_ILL);
        end
    endtask

    task automatic test_reset_midstream();
        issue(I_LUI, 32'h0000_0800);
        step();
        #2 RSTB = 1'b0;
        #1;
        checks++;
        if (ctrl !== C_BUBBLE || ID_EX_PC_OUT !== 32'd0 || ID_EX_IMM !== 32'd0) begin
            failures++; $display("FAIL async_reset: got ctrl=%b pc=%h imm=%h expected 0", ctrl, ID_EX_PC_OUT, ID_EX_IMM);
        end
        issue(I_ADDI_X1_X5, 32'h0000_0804);
        #3 RSTB = 1'b1;
        step();
        checks++;
        if (ctrl !== C_IALU || ID_EX_PC_OUT !== 32'h804 || ID_EX_RS1_DATA !== 32'd0) begin
            failures++; $display("FAIL post_reset_load: got ctrl=%b pc=%h rs1d=%h expected %b 804 0",
                                 ctrl, ID_EX_PC_OUT, ID_EX_RS1_DATA, C_IALU);
        end
    endtask

    initial begin
        test_reset();
        test_write_through();
        test_immediates();
        test_load_use();
        test_x0();
        test_flush_stall();
        test_hazard_combos();
        test_illegal();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_blk.md
# id_stage_blk

Instruction-decode stage of the RV32I pipelined core, directly downstream of the IF stage. It consumes the IF/ID instruction and PC, decodes control signals, generates the immediate, and reads the 32x32 register file. The register file is written from WB. The block detects load-use hazards and registers the decoded result into the ID/EX pipeline register, with stall, bubble and flush handling.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, register count (x0 hardwired to zero)

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  rising-edge clock
- RSTB  in  1  asynchronous active-low reset
- IF_ID_INST_IN  in  32  instruction from IF/ID register
- IF_ID_PC_IN  in  32  PC of that instruction
- ID_STALL  in  1  downstream hold; ID/EX register keeps its value
- ID_FLUSH  in  1  branch/jump taken in EX; ID/EX loads a bubble
- WB_REG_WRITE  in  1  register-file write enable
- WB_RD  in  5  write address
- WB_DATA  in  32  write data
- HAZARD_STALL  out  1  combinational load-use stall; drives IF PC_DISABLE and holds IF/ID
- ID_EX_PC_OUT, ID_EX_RS1_DATA, ID_EX_RS2_DATA, ID_EX_IMM  out  32 each  registered PC, operands, sign-extended immediate
- ID_EX_RS1, ID_EX_RS2, ID_EX_RD  out  5 each  register indices (RS1/RS2 feed EX forwarding)
- ID_EX_FUNCT3  out  3; ID_EX_FUNCT7B5  out  1  (inst[30])
- ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE, ID_EX_BRANCH, ID_EX_JUMP, ID_EX_ALU_SRC, ID_EX_MEM_TO_REG, ID_EX_VALID, ID_EX_ILLEGAL  out  1 each  registered control

## Operation
- Decoded opcodes:
  - R 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
  - LUI 0110111
  - AUIPC 0010111
- Any other opcode: all control signals 0, VALID=1, ILLEGAL=1.
- Immediate sources, all sign-extended from inst[31]:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R type: IMM=0
- Control per opcode:
  - REG_WRITE: R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC
  - MEM_READ and MEM_TO_REG: LOAD
  - MEM_WRITE: STORE
  - BRANCH: BRANCH
  - JUMP: JAL, JALR
  - ALU_SRC: every opcode except R and BRANCH
- Register file:
  - Write happens on the rising edge when WB_REG_WRITE=1 and WB_RD≠0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Write-through: if a read index equals WB_RD in the same cycle (with write enabled, RD≠0), the read returns WB_DATA.
  - Writes proceed regardless of stall, flush or hazard.
- Load-use hazard: HAZARD_STALL=1 when all of the following hold:
  - ID_EX_MEM_READ=1 and ID_EX_VALID=1
  - ID_EX_RD≠0
  - ID_EX_RD matches rs1 (opcode uses rs1: all except LUI, AUIPC, JAL) or rs2 (opcode uses rs2: R, STORE, BRANCH).
- ID/EX update priority at each edge:
  1. ID_FLUSH → bubble
  2. ID_STALL → hold
  3. HAZARD_STALL → bubble
  4. otherwise load the decoded instruction
- Bubble definition: all control bits 0, including VALID and ILLEGAL; data fields 0.

## Timing
- Reset (RSTB low, asynchronous): every ID_EX_* output and all register-file entries go to 0. HAZARD_STALL reflects the reset state (0).
- Latency:
  - One cycle from IF_ID_INST_IN to ID_EX_* outputs.
  - HAZARD_STALL is combinational, same cycle.
- A load followed immediately by a dependent instruction:
  - Cycle n: HAZARD_STALL=1.
  - Edge n+1: bubble enters ID/EX; the dependent instruction stays in IF/ID (held upstream).
  - Cycle n+1: HAZARD_STALL=0.
  - Edge n+2: the dependent instruction issues; EX forwarding covers it.
- Simultaneous events:
  - FLUSH with STALL: flush wins.
  - FLUSH with hazard: bubble, and HAZARD_STALL is still asserted for that cycle.
  - STALL with hazard: hold, and HAZARD_STALL stays asserted.
- Reset deasserted mid-stream: the first edge after release loads normally.

## Test plan
- Reset: RSTB=0 with random inputs → all ID_EX_* = 0, HAZARD_STALL=0. After release, reading x5 returns 0.
- Write-through:
  - Stimulus: WB write x5=0xDEADBEEF in the same cycle as IF_ID_INST_IN=0x00028093 (addi x1,x5,0).
  - Required: next cycle ID_EX_RS1_DATA=0xDEADBEEF, IMM=0, REG_WRITE=1, ALU_SRC=1, RD=1.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) → IMM=0xFFFFFFFC, MEM_WRITE=1, REG_WRITE=0.
  - beq x0,x0,-8 (0xFE000CE3) → IMM=0xFFFFFFF8, BRANCH=1.
  - lui x3,0x12345 (0x123451B7) → IMM=0x12345000.
- Load-use:
  - Stimulus: lw x6,0(x1) (0x0000A303), then add x7,x6,x2 (0x002303B3).
  - Required: HAZARD_STALL=1 for exactly one cycle; one bubble (VALID=0) in ID/EX; then the add issues with RS1=6.
- x0 behaviour:
  - WB write x0=0xFFFFFFFF, then read x0 → 0.
  - lw x0 followed by a consumer of x0 → no stall.
- Flush/stall priority:
  - ID_FLUSH=1 and ID_STALL=1 together → ID_EX_VALID=0 next cycle.
  - ID_STALL alone for 3 cycles → outputs frozen.
  - Undefined opcode 0x0000007F → ILLEGAL=1, VALID=1, all other control bits 0.
